// File: rtl/sdf_stage_if.sv
// Stage-side bundle between one radix-2 SDF butterfly and its control/feedback
// block: input qualifier and SR feedback in, sequencer state, delayed B
// samples, twiddle index and framing status out.
interface sdf_stage_if #(
  parameter int DATA_W = 9,
  parameter int CNT_W  = 4
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] sr_r;
  logic signed [DATA_W-1:0] sr_i;
  logic [1:0]               state;
  logic signed [DATA_W-1:0] b_r;
  logic signed [DATA_W-1:0] b_i;
  logic [CNT_W-1:0]         tw_idx;
  logic                     out_valid;
  logic                     frame_err;

  // Upstream side: launches samples, watches the stage status.
  modport master (
    output in_valid, sr_r, sr_i,
    input  state, b_r, b_i, tw_idx, out_valid, frame_err
  );

  // Stage controller side.
  modport slave (
    input  in_valid, sr_r, sr_i,
    output state, b_r, b_i, tw_idx, out_valid, frame_err
  );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Control and feedback half of one radix-2 SDF FFT stage.
// Sequences the butterfly through WAITING -> FIRST -> SECOND blocks of DEPTH
// cycles, owns the DEPTH-deep complex feedback delay line (SR in, B out) and
// produces the twiddle index, output valid and a protocol-error pulse.
// An aborted frame flushes the delay line so stale SR data never reaches B.
module sdf_stage_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  sdf_stage_if.slave sdf
);

  localparam int DATA_W = 9;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  // Encoding is visible on the state port and is fixed by the butterfly.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIRST   = 2'b01,
    SECOND  = 2'b10,
    WAITING = 2'b11
  } state_t;

  state_t                   state_q;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     drain_q;
  logic                     drain_nxt;
  logic                     last;
  logic                     abort;
  logic                     err_nxt;
  logic [CNT_W-1:0]         tw_p0;
  logic                     vld_p0;
  logic                     err_p0;
  logic signed [DATA_W-1:0] dly_r [DEPTH];
  logic signed [DATA_W-1:0] dly_i [DEPTH];

  // Block counter step: 0..DEPTH-1 then wrap to the start of the next block.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] n;
    if (c == LAST_CNT) begin
      n = '0;
    end else begin
      n = c + 1'b1;
    end
    return n;
  endfunction

  assign last = (cnt_q == LAST_CNT);

  // Next-state, counter, drain flag and error decision for the coming edge.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    drain_nxt = drain_q;
    abort     = 1'b0;
    err_nxt   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_nxt   = '0;
        drain_nxt = 1'b0;
        if (sdf.in_valid) begin
          state_nxt = WAITING;
        end
      end

      WAITING: begin
        if (!sdf.in_valid) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_step(cnt_q);
          if (last) begin
            state_nxt = FIRST;
          end
        end
      end

      FIRST: begin
        if (!sdf.in_valid && !last) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_step(cnt_q);
          if (last) begin
            // A missing sample at the block boundary means this frame is
            // the last one: its SECOND half only drains the delay line.
            state_nxt = SECOND;
            drain_nxt = !sdf.in_valid;
          end
        end
      end

      SECOND: begin
        cnt_nxt = cnt_step(cnt_q);
        if (last) begin
          state_nxt = drain_q ? IDLE : FIRST;
          drain_nxt = 1'b0;
        end else if (!drain_q && !sdf.in_valid) begin
          // The next frame broke off while overlapping this block: finish
          // the current frame's outputs, flag it, and drain afterwards.
          err_nxt   = 1'b1;
          drain_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        drain_nxt = 1'b0;
      end
    endcase

    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      drain_nxt = 1'b0;
      err_nxt   = 1'b1;
    end
  end

  // Sequencer registers plus the registered status outputs derived from the
  // next state, so they line up with the butterfly in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      tw_p0   <= '0;
      vld_p0  <= 1'b0;
      err_p0  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      drain_q <= drain_nxt;
      tw_p0   <= (state_nxt == SECOND) ? cnt_nxt : '0;
      vld_p0  <= (state_nxt == FIRST) || (state_nxt == SECOND);
      err_p0  <= err_nxt;
    end
  end

  // Feedback delay line: free-running shift of SR into B, wiped on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        dly_r[k] <= '0;
        dly_i[k] <= '0;
      end
    end else if (abort) begin
      for (int k = 0; k < DEPTH; k++) begin
        dly_r[k] <= '0;
        dly_i[k] <= '0;
      end
    end else begin
      dly_r[0] <= sdf.sr_r;
      dly_i[0] <= sdf.sr_i;
      for (int k = 1; k < DEPTH; k++) begin
        dly_r[k] <= dly_r[k-1];
        dly_i[k] <= dly_i[k-1];
      end
    end
  end

  assign sdf.state     = state_q;
  assign sdf.b_r       = dly_r[DEPTH-1];
  assign sdf.b_i       = dly_i[DEPTH-1];
  assign sdf.tw_idx    = tw_p0;
  assign sdf.out_valid = vld_p0;
  assign sdf.frame_err = err_p0;

endmodule
